// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine datapath: coin widths, coin
// indices, default coin values and the running-total limit.
package vending_pkg;

    localparam int CENTS_W   = 5;
    localparam int TOTAL_W   = 7;
    localparam int TOTAL_MAX = 99;

    localparam int NUM_COINS = 3;
    localparam int COIN_5    = 0;
    localparam int COIN_10   = 1;
    localparam int COIN_25   = 2;

    localparam int COIN0_CENTS_DEF = 5;
    localparam int COIN1_CENTS_DEF = 10;
    localparam int COIN2_CENTS_DEF = 25;

    typedef logic [CENTS_W-1:0] cents_t;

    // True when a coin value fits the 5-bit event field and is non-zero.
    function automatic bit cents_ok(input int value);
        return (value >= 1) && (value <= 31);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One coin button: 2-flop synchroniser, stability counter and debounced
// level. Emits a single-cycle rise pulse in the cycle the debounced level
// is about to go from 0 to 1.
module btn_debounce #(
    parameter int DB_CYCLES = 100000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_raw,
    output logic rise
);

    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    // Synchronise the raw button, then count consecutive samples that
    // disagree with the debounced level; flip the level after DB_CYCLES.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == level_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_q <= ~level_q;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The level flips on the next edge; a 0->1 flip is a press.
    assign rise = sync_q2 & ~level_q & (cnt == CNT_LAST);

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin button front end: debounces three buttons, turns each press into a
// coin event, queues events in a show-ahead FIFO and hands them out over a
// valid/ack handshake.
// Optional running total (ports total_clr / total_cents) is built when the
// macro COIN_TOTAL_EN is defined.
module coin_input_conditioner
    import vending_pkg::*;
#(
    parameter int DB_CYCLES   = 100000,
    parameter int COIN0_CENTS = COIN0_CENTS_DEF,
    parameter int COIN1_CENTS = COIN1_CENTS_DEF,
    parameter int COIN2_CENTS = COIN2_CENTS_DEF,
    parameter int FIFO_DEPTH  = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [2:0]         btn_raw,
    output logic               coin_valid,
    output logic [CENTS_W-1:0] coin_cents,
    input  logic               coin_ack,
    output logic [CNT_W-1:0]   fifo_count,
    output logic               overflow
`ifdef COIN_TOTAL_EN
    ,
    input  logic               total_clr,
    output logic [TOTAL_W-1:0] total_cents
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (!cents_ok(COIN0_CENTS) || !cents_ok(COIN1_CENTS) || !cents_ok(COIN2_CENTS)) begin : g_bad_cents
        $error("coin values must be in 1..31");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic [NUM_COINS-1:0] rise;
    logic [NUM_COINS-1:0] pending;
    logic [NUM_COINS-1:0] push_oh;
    cents_t               push_cents;
    logic                 push;
    logic                 pop;
    logic                 full;

    cents_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    for (genvar i = 0; i < NUM_COINS; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_btn_debounce (
            .clk     (clk),
            .clr     (clr),
            .btn_raw (btn_raw[i]),
            .rise    (rise[i])
        );
    end

    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign pop  = coin_ack & coin_valid;

    // Fixed-priority arbiter: lowest pending index wins; the full check uses
    // the registered count, so a slot freed by a same-cycle pop is not reused.
    always_comb begin
        push_oh    = '0;
        push_cents = '0;
        if (!full) begin
            if (pending[COIN_5]) begin
                push_oh[COIN_5] = 1'b1;
                push_cents      = cents_t'(COIN0_CENTS);
            end else if (pending[COIN_10]) begin
                push_oh[COIN_10] = 1'b1;
                push_cents       = cents_t'(COIN1_CENTS);
            end else if (pending[COIN_25]) begin
                push_oh[COIN_25] = 1'b1;
                push_cents       = cents_t'(COIN2_CENTS);
            end
        end
        push = |push_oh;
    end

    // Pending bits, FIFO pointers/count and sticky overflow. A press that
    // arrives while its button is still pending is dropped.
    always_ff @(posedge clk) begin
        if (clr) begin
            pending  <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            pending <= (pending & ~push_oh) | (rise & ~pending);
            if (|(rise & pending)) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Event storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_cents;
        end
    end

    assign coin_valid = (count != '0);
    assign coin_cents = coin_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

`ifdef COIN_TOTAL_EN
    localparam int SUM_W = TOTAL_W + 1;

    logic [SUM_W-1:0] total_sum;

    assign total_sum = {1'b0, total_cents} + SUM_W'(coin_cents);

    // Running total of consumed coins, saturating for a 2-digit display.
    always_ff @(posedge clk) begin
        if (clr || total_clr) begin
            total_cents <= '0;
        end else if (pop) begin
            if (total_sum > SUM_W'(TOTAL_MAX)) begin
                total_cents <= TOTAL_W'(TOTAL_MAX);
            end else begin
                total_cents <= total_sum[TOTAL_W-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Self-checking bench for coin_input_conditioner with DB_CYCLES=8 and a
// 4-deep FIFO. Expected coin values go into a scoreboard queue when the
// press is driven and are compared when the event is popped.
module tb_coin_input_conditioner;

    logic       clk;
    logic       clr;
    logic [2:0] btn_raw;
    logic       coin_valid;
    logic [4:0] coin_cents;
    logic       coin_ack;
    logic [2:0] fifo_count;
    logic       overflow;
`ifdef COIN_TOTAL_EN
    logic       total_clr;
    logic [6:0] total_cents;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int sb_q[$];

    typedef struct {
        logic [2:0] btn;
        int         hold;
        bit         expect_ev;
    } vec_t;

    vec_t vecs[8];

    coin_input_conditioner #(
        .DB_CYCLES  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .btn_raw    (btn_raw),
        .coin_valid (coin_valid),
        .coin_cents (coin_cents),
        .coin_ack   (coin_ack),
        .fifo_count (fifo_count),
        .overflow   (overflow)
`ifdef COIN_TOTAL_EN
        ,
        .total_clr  (total_clr),
        .total_cents(total_cents)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cents_of(input int idx);
        case (idx)
            0:       return 5;
            1:       return 10;
            default: return 25;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_push_mask(input logic [2:0] mask);
        for (int b = 0; b < 3; b++) begin
            if (mask[b]) sb_q.push_back(cents_of(b));
        end
    endtask

    task automatic press(input logic [2:0] mask, input int hold, input bit expect_ev);
        if (expect_ev) sb_push_mask(mask);
        btn_raw = mask;
        repeat (hold) tick();
        btn_raw = 3'b000;
        repeat (14) tick();
    endtask

    task automatic pop_check(input string name);
        int exp;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got pop with empty scoreboard expected entry", name);
        end else begin
            exp = sb_q.pop_front();
            check({name, "_valid"}, int'(coin_valid), 1);
            check({name, "_cents"}, int'(coin_cents), exp);
        end
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
    endtask

    task automatic wait_count(input int target, input int budget, input string name);
        int i = 0;
        while (int'(fifo_count) != target && i < budget) begin
            tick();
            i++;
        end
        check(name, int'(fifo_count), target);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        int n_exp;

        clr      = 1'b1;
        btn_raw  = 3'b000;
        coin_ack = 1'b0;
`ifdef COIN_TOTAL_EN
        total_clr = 1'b0;
`endif

        vecs[0] = '{3'b010, 5,  1'b0};
        vecs[1] = '{3'b010, 20, 1'b1};
        vecs[2] = '{3'b010, 20, 1'b1};
        vecs[3] = '{3'b001, 3,  1'b0};
        vecs[4] = '{3'b100, 7,  1'b0};
        vecs[5] = '{3'b100, 8,  1'b1};
        vecs[6] = '{3'b101, 12, 1'b1};
        vecs[7] = '{3'b011, 16, 1'b1};

        // Reset and idle
        do_reset();
        for (int c = 0; c < 10; c++) begin
            check("idle_valid", int'(coin_valid), 0);
            check("idle_cents", int'(coin_cents), 0);
            check("idle_count", int'(fifo_count), 0);
            check("idle_overflow", int'(overflow), 0);
            tick();
        end

        // Table-driven presses and glitches
        for (int v = 0; v < 8; v++) begin
            n_exp = 0;
            if (vecs[v].expect_ev) begin
                for (int b = 0; b < 3; b++) if (vecs[v].btn[b]) n_exp++;
            end
            if (vecs[v].expect_ev) sb_push_mask(vecs[v].btn);
            btn_raw = vecs[v].btn;
            repeat (vecs[v].hold) tick();
            btn_raw = 3'b000;
            repeat (20) tick();
            check($sformatf("vec%0d_count", v), int'(fifo_count), n_exp);
            check($sformatf("vec%0d_valid", v), int'(coin_valid), (n_exp != 0) ? 1 : 0);
            while (sb_q.size() != 0) pop_check($sformatf("vec%0d_pop", v));
            check($sformatf("vec%0d_empty_cents", v), int'(coin_cents), 0);
        end

        // Simultaneous presses enqueue on consecutive cycles, lowest index first
        sb_push_mask(3'b111);
        btn_raw = 3'b111;
        wait_count(1, 30, "simul_step1");
        tick();
        check("simul_step2", int'(fifo_count), 2);
        tick();
        check("simul_step3", int'(fifo_count), 3);
        btn_raw = 3'b000;
        repeat (14) tick();
        pop_check("simul_pop0");
        pop_check("simul_pop1");
        pop_check("simul_pop2");
        check("simul_empty", int'(coin_valid), 0);

        // Reset mid-press discards partial debounce
        btn_raw = 3'b010;
        repeat (6) tick();
        btn_raw = 3'b000;
        do_reset();
        repeat (20) tick();
        check("midreset_count", int'(fifo_count), 0);

        // Full FIFO holds a pending press; a further press overflows
        for (int p = 0; p < 5; p++) press(3'b100, 10, 1'b1);
        check("full_count", int'(fifo_count), 4);
        check("full_no_overflow", int'(overflow), 0);
        press(3'b100, 10, 1'b0);
        check("full_overflow", int'(overflow), 1);
        check("full_count_after_drop", int'(fifo_count), 4);
        pop_check("full_pop0");
        tick();
        tick();
        check("full_refill", int'(fifo_count), 4);
        for (int p = 1; p < 5; p++) pop_check($sformatf("full_pop%0d", p));
        check("full_drained", int'(fifo_count), 0);
        check("overflow_sticky", int'(overflow), 1);
        do_reset();
        check("clr_overflow", int'(overflow), 0);

        // Buffered events are discarded by reset
        press(3'b001, 10, 1'b1);
        check("pre_clr_count", int'(fifo_count), 1);
        do_reset();
        check("clr_count", int'(fifo_count), 0);
        check("clr_valid", int'(coin_valid), 0);

        // Push and pop in the same cycle
        press(3'b010, 10, 1'b1);
        press(3'b100, 10, 1'b1);
        check("pp_count_before", int'(fifo_count), 2);
        sb_q.push_back(5);
        btn_raw = 3'b001;
        repeat (10) tick();
        check("pp_count_prepush", int'(fifo_count), 2);
        check("pp_head", int'(coin_cents), sb_q.pop_front());
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        check("pp_count_after", int'(fifo_count), 2);
        btn_raw = 3'b000;
        repeat (14) tick();
        pop_check("pp_pop0");
        pop_check("pp_pop1");
        check("pp_empty", int'(fifo_count), 0);

`ifdef COIN_TOTAL_EN
        // Running total saturates at 99 and clears on total_clr
        do_reset();
        check("total_reset", int'(total_cents), 0);
        for (int p = 0; p < 4; p++) press(3'b100, 10, 1'b1);
        press(3'b010, 10, 1'b1);
        pop_check("tot_pop0");
        check("total_25", int'(total_cents), 25);
        tick();
        pop_check("tot_pop1");
        check("total_50", int'(total_cents), 50);
        pop_check("tot_pop2");
        check("total_75", int'(total_cents), 75);
        pop_check("tot_pop3");
        check("total_sat", int'(total_cents), 99);
        pop_check("tot_pop4");
        check("total_sat_hold", int'(total_cents), 99);
        total_clr = 1'b1;
        tick();
        total_clr = 1'b0;
        check("total_clr", int'(total_cents), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
